// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle RV32I-subset control FSM; ports clk, rst (async active-low), instr, alu_signbit, mem_ack in; ALU/mux selects, PC/IR/mem/regfile enables, sticky illegal out
module alu_ctrl_fsm (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        alu_signbit,
  input  logic        mem_ack,
  output logic [3:0]  alu_sel,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_sel,
  output logic [1:0]  result_src,
  output logic        pc_src,
  output logic        pc_write,
  output logic        ir_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_write,
  output logic        illegal
);
  localparam logic [3:0] ALU_AND = 4'd0, ALU_OR = 4'd1, ALU_SLT = 4'd2, ALU_ADD = 4'd3, ALU_SLL = 4'd4,
                         ALU_XOR = 4'd5, ALU_SUB = 4'd6, ALU_EQ = 4'd7, ALU_BLT = 4'd8;
  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LW = 7'b0000011, OP_SW = 7'b0100011,
                         OP_BR = 7'b1100011, OP_JAL = 7'b1101111, OP_LUI = 7'b0110111;
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, EXEC_R, EXEC_I, MEMADDR, MEM, BRANCH, JAL, LUI, WB_ALU, WB_MEM, TRAP
  } state_t;
  state_t state, next;
  logic illegal_q;
  logic [3:0] sel;
  logic [1:0] src_a, src_b, rsrc;
  logic [2:0] imm;
  logic pcs, pcw, irw, mreq, mwe, rw;
  logic [6:0] op;
  logic [2:0] f3;
  logic f3_ok, br_ok, is_sw;
  logic [3:0] op_sel;
  logic unused_bits;
  assign op = instr[6:0];
  assign f3 = instr[14:12];
  assign is_sw = op == OP_SW;
  assign f3_ok = f3 != 3'b011 && f3 != 3'b101;
  assign br_ok = !f3[1];
  assign op_sel = f3 == 3'b000 ? ALU_ADD : f3 == 3'b111 ? ALU_AND : f3 == 3'b110 ? ALU_OR :
                  f3 == 3'b100 ? ALU_XOR : f3 == 3'b001 ? ALU_SLL : ALU_SLT;
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state <= next;
      illegal_q <= illegal_q | (next == TRAP);
    end
  always_comb begin
    next = state;
    sel = ALU_ADD;
    src_a = 2'd0;
    src_b = 2'd0;
    imm = 3'd0;
    rsrc = 2'd0;
    pcs = 1'b0;
    pcw = 1'b0;
    irw = 1'b0;
    mreq = 1'b0;
    mwe = 1'b0;
    rw = 1'b0;
    case (state)
      FETCH: begin
        mreq = 1'b1;
        src_b = 2'd2;
        irw = mem_ack;
        pcw = mem_ack;
        next = mem_ack ? DECODE : FETCH;
      end
      DECODE: begin
        src_a = 2'd1;
        src_b = 2'd1;
        imm = op == OP_BR ? 3'd2 : op == OP_JAL ? 3'd3 : 3'd0;
        next = op == OP_R ? EXEC_R : op == OP_I ? EXEC_I : (op == OP_LW || is_sw) ? MEMADDR :
               op == OP_BR ? BRANCH : op == OP_JAL ? JAL : op == OP_LUI ? LUI : TRAP;
      end
      EXEC_R: begin
        src_a = 2'd2;
        sel = !f3_ok ? ALU_ADD : (f3 == 3'b000 && instr[30]) ? ALU_SUB : op_sel;
        next = f3_ok ? WB_ALU : TRAP;
      end
      EXEC_I: begin
        src_a = 2'd2;
        src_b = 2'd1;
        sel = f3_ok ? op_sel : ALU_ADD;
        next = f3_ok ? WB_ALU : TRAP;
      end
      MEMADDR: begin
        src_a = 2'd2;
        src_b = 2'd1;
        imm = is_sw ? 3'd1 : 3'd0;
        next = MEM;
      end
      MEM: begin
        mreq = 1'b1;
        mwe = is_sw;
        next = !mem_ack ? MEM : is_sw ? FETCH : WB_MEM;
      end
      BRANCH: begin
        src_a = 2'd2;
        pcs = 1'b1;
        sel = !br_ok ? ALU_ADD : f3[2] ? ALU_BLT : ALU_EQ;
        // funct3[0] inverts the compare: bne/bge take on a clear flag
        pcw = br_ok & (alu_signbit ^ f3[0]);
        next = br_ok ? FETCH : TRAP;
      end
      JAL: begin
        rw = 1'b1;
        rsrc = 2'd2;
        pcs = 1'b1;
        pcw = 1'b1;
        next = FETCH;
      end
      LUI: begin
        src_a = 2'd3;
        src_b = 2'd1;
        imm = 3'd4;
        next = WB_ALU;
      end
      WB_ALU: begin
        rw = 1'b1;
        next = FETCH;
      end
      WB_MEM: begin
        rw = 1'b1;
        rsrc = 2'd1;
        next = FETCH;
      end
      default: next = TRAP;
    endcase
  end
  // reset forces every output low without waiting for a clock edge
  assign alu_sel    = rst ? sel : 4'd0;
  assign alu_src_a  = rst ? src_a : 2'd0;
  assign alu_src_b  = rst ? src_b : 2'd0;
  assign imm_sel    = rst ? imm : 3'd0;
  assign result_src = rst ? rsrc : 2'd0;
  assign pc_src     = rst & pcs;
  assign pc_write   = rst & pcw;
  assign ir_write   = rst & irw;
  assign mem_req    = rst & mreq;
  assign mem_we     = rst & mwe;
  assign reg_write  = rst & rw;
  assign illegal    = rst & illegal_q;
endmodule

// File: tb/tb_alu_ctrl_fsm.sv
// tb_alu_ctrl_fsm: per-cycle output checks of alu_ctrl_fsm against an instruction-level expected-sequence model
module tb_alu_ctrl_fsm;
  logic clk, rst, alu_signbit, mem_ack;
  logic [31:0] instr;
  logic [3:0] alu_sel;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [2:0] imm_sel;
  logic pc_src, pc_write, ir_write, mem_req, mem_we, reg_write, illegal;
  logic [19:0] got;
  int checks = 0, passes = 0;
  typedef struct packed { logic [1:0] ack; logic [19:0] v; } step_t;
  step_t q[$];
  int alu_tab[8] = '{3, 4, 2, -1, 5, -1, 1, 0};

  alu_ctrl_fsm dut (
    .clk(clk), .rst(rst), .instr(instr), .alu_signbit(alu_signbit), .mem_ack(mem_ack),
    .alu_sel(alu_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_sel(imm_sel),
    .result_src(result_src), .pc_src(pc_src), .pc_write(pc_write), .ir_write(ir_write),
    .mem_req(mem_req), .mem_we(mem_we), .reg_write(reg_write), .illegal(illegal)
  );

  assign got = {alu_sel, alu_src_a, alu_src_b, imm_sel, result_src, pc_src, pc_write, ir_write,
                mem_req, mem_we, reg_write, illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [19:0] vec(input int sel, a, b, imm, rs, pcs, pcw, irw, mreq, mwe, rw, ill);
    logic [3:0] s4 = sel[3:0];
    return {s4, a[1:0], b[1:0], imm[2:0], rs[1:0], pcs[0], pcw[0], irw[0], mreq[0], mwe[0], rw[0], ill[0]};
  endfunction

  function automatic logic [19:0] trap_v();
    return vec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic logic [19:0] fetch_v(input int ack);
    return vec(3, 0, 2, 0, 0, 0, ack, ack, 1, 0, 0, 0);
  endfunction

  // expected cycle sequence of one instruction; ack field 2 = don't-care (driven randomly)
  task automatic build(input logic [31:0] ins, input bit sb, input int fd, input int md);
    logic [6:0] op;
    logic [2:0] f3;
    int s;
    op = ins[6:0];
    f3 = ins[14:12];
    q.delete();
    for (int i = 0; i < fd; i++) q.push_back('{2'd0, fetch_v(0)});
    q.push_back('{2'd1, fetch_v(1)});
    q.push_back('{2'd2, vec(3, 1, 1, op == 7'b1100011 ? 2 : op == 7'b1101111 ? 3 : 0, 0, 0, 0, 0, 0, 0, 0, 0)});
    case (op)
      7'b0110011, 7'b0010011: begin
        s = alu_tab[f3];
        if (op == 7'b0110011 && f3 == 3'd0 && ins[30]) s = 6;
        q.push_back('{2'd2, vec(s < 0 ? 3 : s, 2, op == 7'b0110011 ? 0 : 1, 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        q.push_back('{2'd2, s < 0 ? trap_v() : vec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
      end
      7'b0000011, 7'b0100011: begin
        q.push_back('{2'd2, vec(3, 2, 1, op == 7'b0100011 ? 1 : 0, 0, 0, 0, 0, 0, 0, 0, 0)});
        for (int i = 0; i < md; i++) q.push_back('{2'd0, vec(3, 0, 0, 0, 0, 0, 0, 0, 1, op == 7'b0100011 ? 1 : 0, 0, 0)});
        q.push_back('{2'd1, vec(3, 0, 0, 0, 0, 0, 0, 0, 1, op == 7'b0100011 ? 1 : 0, 0, 0)});
        if (op == 7'b0000011) q.push_back('{2'd2, vec(3, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0)});
      end
      7'b1100011: begin
        if (f3 == 0 || f3 == 1 || f3 == 4 || f3 == 5)
          q.push_back('{2'd2, vec(f3 >= 4 ? 8 : 7, 2, 0, 0, 0, 1, int'(sb) ^ int'(f3[0]), 0, 0, 0, 0, 0)});
        else begin
          q.push_back('{2'd2, vec(3, 2, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0)});
          q.push_back('{2'd2, trap_v()});
        end
      end
      7'b1101111: q.push_back('{2'd2, vec(3, 0, 0, 0, 2, 1, 1, 0, 0, 0, 1, 0)});
      7'b0110111: begin
        q.push_back('{2'd2, vec(3, 3, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0)});
        q.push_back('{2'd2, vec(3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0)});
      end
      default: q.push_back('{2'd2, trap_v()});
    endcase
  endtask

  task automatic run(input logic [31:0] ins, input bit sb, input int fd, input int md, input string name);
    build(ins, sb, fd, md);
    foreach (q[i]) begin
      @(negedge clk);
      instr = ins;
      alu_signbit = sb;
      mem_ack = q[i].ack == 2'd2 ? 1'($urandom_range(1)) : q[i].ack[0];
      #1;
      if (got !== q[i].v) $display("FAIL %s step %0d: got %h expected %h", name, i, got, q[i].v);
      else passes++;
      checks++;
    end
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b0;
    #1;
    if (got !== 20'h0) $display("FAIL %s reset outputs: got %h expected 00000", name, got);
    else passes++;
    checks++;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    if (got !== 20'h0) $display("FAIL reset_initial: got %h expected 00000", got);
    else passes++;
    checks++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (got !== fetch_v(0)) $display("FAIL reset_release: got %h expected %h", got, fetch_v(0));
    else passes++;
    checks++;
  endtask

  task automatic test_directed();
    run(32'h002081B3, 0, 0, 0, "add");
    run(32'h402081B3, 0, 1, 0, "sub");
    run(32'h0020A193, 0, 0, 0, "slti");
    run(32'h00208063, 1, 0, 0, "beq_taken");
    run(32'h00209063, 1, 0, 0, "bne_not_taken");
    run(32'h0020D063, 0, 0, 0, "bge_taken");
    run(32'h0020C063, 0, 0, 0, "blt_not_taken");
    run(32'h0000A183, 0, 0, 3, "lw_wait3");
    run(32'h0030A023, 0, 2, 1, "sw");
    run(32'h0000006F, 0, 0, 0, "jal");
    run(32'h000011B7, 0, 0, 0, "lui");
    run(32'h00209193, 0, 0, 0, "slli");
  endtask

  task automatic test_random();
    logic [31:0] ins;
    int cls;
    int r_f3[6] = '{0, 1, 2, 4, 6, 7};
    int b_f3[4] = '{0, 1, 4, 5};
    logic [6:0] ops[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b0110111};
    for (int n = 0; n < 60; n++) begin
      ins = $urandom;
      cls = $urandom_range(6);
      ins[6:0] = ops[cls];
      if (cls <= 1) ins[14:12] = 3'(r_f3[$urandom_range(5)]);
      if (cls == 4) ins[14:12] = 3'(b_f3[$urandom_range(3)]);
      run(ins, 1'($urandom_range(1)), $urandom_range(2), $urandom_range(3), "random");
    end
  endtask

  task automatic test_trap();
    run(32'h0000007F, 0, 0, 0, "trap_opcode");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_ack = 1'($urandom_range(1));
      #1;
      if (got !== trap_v()) $display("FAIL trap_hold cycle %0d: got %h expected %h", i, got, trap_v());
      else passes++;
      checks++;
    end
    do_reset("trap_clear");
    run(32'h0020D1B3, 0, 0, 0, "trap_r_funct3");
    do_reset("trap_r_clear");
    run(32'h0020A063, 0, 0, 0, "trap_br_funct3");
    do_reset("trap_br_clear");
    run(32'h002081B3, 0, 0, 0, "after_trap_add");
  endtask

  task automatic test_reset_in_mem();
    build(32'h0000A183, 0, 0, 5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr = 32'h0000A183;
      mem_ack = q[i].ack == 2'd1;
      #1;
      if (got !== q[i].v) $display("FAIL mem_reset_setup step %0d: got %h expected %h", i, got, q[i].v);
      else passes++;
      checks++;
    end
    #2;
    rst = 1'b0;
    #1;
    if (mem_req !== 1'b0 || got !== 20'h0) $display("FAIL mem_reset_drop: got %h expected 00000", got);
    else passes++;
    checks++;
    @(negedge clk);
    rst = 1'b1;
    #1;
    if (got !== fetch_v(0)) $display("FAIL mem_reset_fetch: got %h expected %h", got, fetch_v(0));
    else passes++;
    checks++;
    @(posedge clk);
    #1;
    if (mem_req !== 1'b1) $display("FAIL mem_reset_first_edge: mem_req got %b expected 1", mem_req);
    else passes++;
    checks++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      run(32'h0000A183, 0, 0, 0, "b2b_lw");
      run(32'h0030A023, 0, 0, 0, "b2b_sw");
      run(32'h00208063, 0, 0, 0, "b2b_beq");
    end
  endtask

  initial begin
    rst = 1'b0;
    instr = '0;
    alu_signbit = 1'b0;
    mem_ack = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_trap();
    test_reset_in_mem();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
